// File: rtl/wb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_monitor
// Description : Mirrors the write-back register stream into a shadow register
//               file, detects program end by write-back inactivity, keeps
//               cycle/write counters and streams the shadow file out on request.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_monitor #(
  parameter  int REG_NUM    = 32,
  parameter  int DATA_W     = 32,
  parameter  int IDLE_LIMIT = 8,
  parameter  int CNT_W      = 32,
  localparam int AW         = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              dump_req_i,
  output logic              halt_o,
  output logic              dump_valid_o,
  output logic [AW-1:0]     dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o,
  output logic [CNT_W-1:0]  zero_wr_cnt_o
);

  localparam int IW = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_DUMP   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_idle;
  logic [DATA_W-1:0] r_shadow [REG_NUM];

  logic              w_in_range;
  logic              w_wr;
  logic              w_reg_wr;
  logic              w_zero_wr;
  logic              w_last;
  logic [IW-1:0]     w_idle_inc;
  logic [AW-1:0]     w_next_addr;

  // Out-of-range destinations are treated as no write-back activity at all.
  assign w_in_range  = (int'(wb_addr_i) < REG_NUM);
  assign w_wr        = wb_en_i && w_in_range;
  assign w_reg_wr    = w_wr && (wb_addr_i != '0);
  assign w_zero_wr   = w_wr && (wb_addr_i == '0);
  assign w_idle_inc  = r_idle + IW'(1);
  assign w_last      = (dump_addr_o == AW'(REG_NUM - 1));
  assign w_next_addr = dump_addr_o + AW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_RUN;
      r_idle        <= '0;
      halt_o        <= 1'b0;
      dump_valid_o  <= 1'b0;
      dump_addr_o   <= '0;
      dump_data_o   <= '0;
      dump_done_o   <= 1'b0;
      cycle_cnt_o   <= '0;
      wr_cnt_o      <= '0;
      zero_wr_cnt_o <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      case (r_state)
        S_RUN, S_HALTED: begin
          if (w_reg_wr) begin
            r_shadow[wb_addr_i] <= wb_data_i;
            wr_cnt_o            <= wr_cnt_o + CNT_W'(1);
          end
          if (w_zero_wr) begin
            zero_wr_cnt_o <= zero_wr_cnt_o + CNT_W'(1);
          end
          if (r_state == S_RUN) begin
            cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
          end

          // The dump request wins; halt_o keeps whatever it had on entry.
          if (dump_req_i) begin
            r_state      <= S_DUMP;
            dump_valid_o <= 1'b1;
            dump_addr_o  <= '0;
            dump_data_o  <= r_shadow[0];
          end else if (w_wr) begin
            r_idle  <= '0;
            r_state <= S_RUN;
            halt_o  <= 1'b0;
          end else if (r_state == S_RUN) begin
            r_idle <= w_idle_inc;
            if (w_idle_inc == IW'(IDLE_LIMIT)) begin
              r_state <= S_HALTED;
              halt_o  <= 1'b1;
            end
          end
        end

        S_DUMP: begin
          if (w_last) begin
            r_state      <= S_DONE;
            dump_valid_o <= 1'b0;
            dump_done_o  <= 1'b1;
          end else begin
            dump_addr_o <= w_next_addr;
            dump_data_o <= r_shadow[w_next_addr];
          end
        end

        S_DONE: begin
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
